apb_completer: RTL and testbench
================================

// Module: apb_completer
//
// PURPOSE
// APB4 completer (responder) that answers transfers issued by the APB bridge.
// Holds a small word-addressed register file, inserts programmable wait states
// and flags errors on PSLVERR. Errors cover bad address, read-only write and
// requester protocol violations. Sits on the peripheral side of apb_if.
//
// PARAMETERS
// ADDR_WIDTH   32            paddr width
// DATA_WIDTH   32            pwdata/prdata width; byte lanes = DATA_WIDTH/8
// NUM_REGS     16            register count; word index = paddr[..:2]
// WAIT_STATES  1             extra PREADY-low access cycles beyond the minimum 1 (0..15)
// ID_VALUE     32'hA9B0_0001 read-only contents of register 0
//
// PORTS
// pclk     in   1             clock, all state on rising edge
// presetn  in   1             asynchronous active-low reset
// psel     in   1             completer select
// penable  in   1             access phase
// pwrite   in   1             1=write, 0=read
// paddr    in   ADDR_WIDTH    byte address
// pwdata   in   DATA_WIDTH    write data
// pstrb    in   DATA_WIDTH/8  write byte strobes
// prdata   out  DATA_WIDTH    read data, valid only while pready=1
// pready   out  1             transfer complete, registered
// pslverr  out  1             error response, valid only while pready=1
//
// BEHAVIOUR
// - Reset (presetn=0, any time incl. mid-transfer): pready=0, pslverr=0,
//   prdata=0, regs 2..N-1=0, err_cnt=0, state=IDLE, wait counter=0.
// - Regs: 0=ID_VALUE (RO); 1=err_cnt (RO, 16-bit zero-extended, saturates at
//   16'hFFFF); 2..NUM_REGS-1 read/write.
// - FSM IDLE/ACCESS/RESP/ABORT. Outputs registered; prdata=0 unless pready=1.
// - IDLE: edge sampling psel=1 & penable=0 -> capture paddr, pwrite, pwdata,
//   pstrb; cnt<=WAIT_STATES; go ACCESS. psel=1 & penable=1 in IDLE is ignored.
// - ACCESS, per edge:
//   * psel=0, or psel=1 & penable=0 -> protocol violation -> ABORT.
//   * psel=1 & penable=1 & cnt!=0 -> cnt--.
//   * psel=1 & penable=1 & cnt==0 -> complete -> RESP with pready=1.
// - Latency: access phase sees WAIT_STATES+1 cycles with pready=0, then 1 with pready=1.
// - Completion decode (first match wins):
//   * paddr[1:0]!=0 -> error.
//   * index>=NUM_REGS -> error.
//   * write to reg 0 or reg 1 -> error.
//   * else OK.
//   OK write updates byte i where pstrb[i]=1 (pstrb=0: no change, OK).
//   OK read: prdata=reg. Error: no write, prdata=0, pslverr=1.
// - ABORT: pready=1, pslverr=1, prdata=0 for one cycle; no register write.
// - RESP/ABORT last exactly one cycle, then pready<=0, pslverr<=0.
//   If that edge samples psel=1 & penable=0, capture a new setup -> ACCESS
//   (back-to-back). Otherwise go IDLE.
// - err_cnt += 1 on every cycle with pready=1 & pslverr=1. No increment at 16'hFFFF.
// - Reads ignore pstrb. Captured pwdata is used; later pwdata changes are ignored.
//
// TESTING
// 1 Reset, WAIT_STATES=1, read 0x0 -> prdata=A9B00001, pslverr=0;
//   exactly 2 cycles with pready=0 in access.
// 2 Write 0x8=DEADBEEF pstrb=F, then write 0x8=00000011 pstrb=1, read 0x8
//   -> DEADBE11, all OKAY.
// 3 Read 0x3 -> pslverr=1, prdata=0. Read 0x40 (index 16) -> pslverr=1.
//   Write 0x0 -> pslverr=1, reg0 unchanged. Read 0x4 -> 00000003.
// 4 Setup 0x8, 1 access cycle, drop psel -> one-cycle pready=1 & pslverr=1,
//   reg 2 unchanged, err_cnt+1.
// 5 Back-to-back: new setup in the RESP cycle -> second transfer completes
//   with no IDLE cycle. Sweep WAIT_STATES 0 and 3 -> wait cycles 1 and 4.
// 6 Assert presetn=0 mid-ACCESS of a write to 0xC -> outputs 0, reg 3=0;
//   next read 0xC -> 00000000 OKAY.

Source files
------------

// File: rtl/apb_completer.sv
// APB4 completer: word-addressed register file, programmable wait states, PSLVERR on bad access.
// Latency WAIT_STATES+1 pready-low access cycles; requester is stalled only via registered pready.
module apb_completer #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ABORT} state_t;

  state_t                state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic                  cap_write;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [STRB_W-1:0]     cap_strb;
  logic                  capture, do_write, pready_n, pslverr_n;
  logic [DATA_WIDTH-1:0] prdata_n, rd_data;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [15:0]           err_cnt;
  logic [IDX_W-1:0]      idx;
  logic                  dec_err, setup;

  assign setup = psel & ~penable;
  assign idx   = cap_addr[IDX_W+1:2];

  // Decode order matters only for readability; every failing term yields the same error response.
  assign dec_err = (cap_addr[1:0] != 2'b00)
                || ({2'b00, cap_addr[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(NUM_REGS))
                || (cap_write && (idx <= IDX_W'(1)));

  always_comb begin
    rd_data = regs[idx];
    if (idx == IDX_W'(0))      rd_data = DATA_WIDTH'(ID_VALUE);
    else if (idx == IDX_W'(1)) rd_data = DATA_WIDTH'(err_cnt);
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    capture   = 1'b0;
    do_write  = 1'b0;
    pready_n  = 1'b0;
    pslverr_n = 1'b0;
    prdata_n  = '0;
    case (state)
      IDLE: begin
        if (setup) begin
          capture = 1'b1;
          cnt_n   = 4'(WAIT_STATES);
          state_n = ACCESS;
        end
      end
      ACCESS: begin
        if (!psel || !penable) begin
          state_n   = ABORT;
          pready_n  = 1'b1;
          pslverr_n = 1'b1;
        end else if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          state_n  = RESP;
          pready_n = 1'b1;
          if (dec_err)        pslverr_n = 1'b1;
          else if (cap_write) do_write  = 1'b1;
          else                prdata_n  = rd_data;
        end
      end
      default: begin
        // RESP/ABORT: a setup presented during the response cycle starts the next transfer directly.
        if (setup) begin
          capture = 1'b1;
          cnt_n   = 4'(WAIT_STATES);
          state_n = ACCESS;
        end else begin
          state_n = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      cnt       <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      prdata    <= '0;
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
      cap_strb  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pready  <= pready_n;
      pslverr <= pslverr_n;
      prdata  <= prdata_n;
      if (capture) begin
        cap_addr  <= paddr;
        cap_write <= pwrite;
        cap_wdata <= pwdata;
        cap_strb  <= pstrb;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int r = 0; r < int'(NUM_REGS); r++) regs[r] <= '0;
    end else if (do_write) begin
      for (int i = 0; i < int'(STRB_W); i++) begin
        if (cap_strb[i]) regs[idx][8*i +: 8] <= cap_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      err_cnt <= '0;
    end else if (pready && pslverr && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_apb_completer.sv
// Bench for apb_completer: three instances (WAIT_STATES 1, 0, 3) driven from a shared
// transfer task; expected responses are queued at issue time and checked by a monitor.
module tb_apb_completer;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic        pclk, presetn;
  logic        psel[3], penable[3], pwrite[3], pready[3], pslverr[3];
  logic [31:0] paddr[3], pwdata[3], prdata[3];
  logic [3:0]  pstrb[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_completer #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16),
      .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
      .ID_VALUE(32'hA9B0_0001)
    ) u_dut (
      .pclk(pclk), .presetn(presetn), .psel(psel[g]), .penable(penable[g]),
      .pwrite(pwrite[g]), .paddr(paddr[g]), .pwdata(pwdata[g]), .pstrb(pstrb[g]),
      .prdata(prdata[g]), .pready(pready[g]), .pslverr(pslverr[g])
    );
  end

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  typedef struct {
    int          g;
    bit          err;
    logic [31:0] rdata;
    int          waits;
    bit          chk_wait;
    bit          chk_data;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          wcnt[3];
  logic [31:0] mregs[3][16];
  int          merr[3];
  exp_t        mon_e;

  function automatic int ws_of(int g);
    return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: registers as a plain array, error counter as an integer.
  task automatic model_reset();
    for (int g = 0; g < 3; g++) begin
      merr[g] = 0;
      for (int r = 0; r < 16; r++) mregs[g][r] = 32'h0;
    end
  endtask

  task automatic model_err(int g);
    if (merr[g] < 65535) merr[g]++;
  endtask

  task automatic model_xfer(int g, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                            output bit err, output logic [31:0] rd);
    int unsigned widx;
    widx = a >> 2;
    err  = (a % 4 != 0) || (widx >= 16) || (w && widx < 2);
    rd   = 32'h0;
    if (err) begin
      model_err(g);
    end else if (w) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mregs[g][widx][8*b +: 8] = d[8*b +: 8];
    end else if (widx == 0) begin
      rd = ID;
    end else if (widx == 1) begin
      rd = merr[g];
    end else begin
      rd = mregs[g][widx];
    end
  endtask

  task automatic wait_ready(int g, string nm);
    bit ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge pclk);
      if (pready[g]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no pready on dut%0d, required pready within 64 cycles", nm, g);
    end
  endtask

  task automatic xfer(int g, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                      bit hold, string nm);
    exp_t        e;
    bit          err;
    logic [31:0] rd;
    model_xfer(g, w, a, d, s, err, rd);
    e.g = g; e.err = err; e.rdata = rd; e.waits = ws_of(g) + 1;
    e.chk_wait = 1'b1; e.chk_data = !w || err; e.name = nm;
    sb.push_back(e);
    psel[g] = 1'b1; penable[g] = 1'b0; pwrite[g] = w;
    paddr[g] = a; pwdata[g] = d; pstrb[g] = s;
    @(posedge pclk); #1;
    penable[g] = 1'b1;
    pwdata[g]  = $urandom();
    pstrb[g]   = 4'($urandom_range(0, 15));
    wait_ready(g, nm);
    if (!hold) begin
      @(posedge pclk); #1;
      psel[g] = 1'b0; penable[g] = 1'b0;
    end else begin
      #1;
    end
  endtask

  task automatic abort_xfer(int g, logic [31:0] a, string nm);
    exp_t e;
    e.g = g; e.err = 1'b1; e.rdata = 32'h0; e.waits = 0;
    e.chk_wait = 1'b0; e.chk_data = 1'b1; e.name = nm;
    sb.push_back(e);
    model_err(g);
    psel[g] = 1'b1; penable[g] = 1'b0; pwrite[g] = 1'b1;
    paddr[g] = a; pwdata[g] = 32'hCAFE_F00D; pstrb[g] = 4'hF;
    @(posedge pclk); #1;
    penable[g] = 1'b1;
    @(posedge pclk); #1;
    psel[g] = 1'b0; penable[g] = 1'b0;
    wait_ready(g, nm);
    @(posedge pclk); #1;
  endtask

  always @(negedge pclk) begin
    for (int g = 0; g < 3; g++) begin
      if (pready[g]) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: got pready on dut%0d, required no response", g);
        end else begin
          mon_e = sb.pop_front();
          chk({mon_e.name, "_dut"}, 32'(g), 32'(mon_e.g));
          chk({mon_e.name, "_pslverr"}, 32'(pslverr[g]), 32'(mon_e.err));
          if (mon_e.chk_data) chk({mon_e.name, "_prdata"}, prdata[g], mon_e.rdata);
          if (mon_e.chk_wait) chk({mon_e.name, "_waits"}, 32'(wcnt[g]), 32'(mon_e.waits));
        end
        wcnt[g] = 0;
      end else begin
        if (psel[g] && penable[g]) wcnt[g]++;
        if (!presetn) wcnt[g] = 0;
        chk("idle_prdata_pslverr", {prdata[g][30:0], pslverr[g]}, 32'h0);
      end
    end
  end

  initial begin
    int g, n, r;
    bit w;
    logic [31:0] a;

    for (int i = 0; i < 3; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
      paddr[i] = '0; pwdata[i] = '0; pstrb[i] = '0; wcnt[i] = 0;
    end
    model_reset();
    presetn = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_pready", 32'(pready[i]), 32'h0);
      chk("reset_prdata", prdata[i], 32'h0);
    end
    @(posedge pclk); #1;
    presetn = 1'b1;

    xfer(0, 0, 32'h0, 0, 4'h0, 0, "read_id");
    xfer(0, 1, 32'h8, 32'hDEAD_BEEF, 4'hF, 0, "wr8_full");
    xfer(0, 1, 32'h8, 32'h0000_0011, 4'h1, 0, "wr8_byte0");
    xfer(0, 0, 32'h8, 0, 4'h0, 0, "rd8");
    xfer(0, 0, 32'h3, 0, 4'hF, 0, "rd_unaligned");
    xfer(0, 0, 32'h40, 0, 4'h0, 0, "rd_oob");
    xfer(0, 1, 32'h0, 32'h1234_5678, 4'hF, 0, "wr_id_ro");
    xfer(0, 0, 32'h0, 0, 4'h0, 0, "rd_id_after_wr");
    xfer(0, 0, 32'h4, 0, 4'h0, 0, "rd_errcnt");
    xfer(0, 1, 32'h8, 32'hFFFF_FFFF, 4'h0, 0, "wr8_nostrb");

    abort_xfer(0, 32'h8, "abort");
    xfer(0, 0, 32'h8, 0, 4'h0, 0, "rd8_after_abort");
    xfer(0, 0, 32'h4, 0, 4'h0, 0, "rd_errcnt_abort");

    for (int d = 0; d < 3; d++) begin
      xfer(d, 1, 32'h10, 32'h0BAD_F00D + d, 4'hF, 1, "b2b_wr");
      xfer(d, 0, 32'h10, 0, 4'h0, 1, "b2b_rd");
      xfer(d, 0, 32'h0, 0, 4'h0, 0, "b2b_rd_id");
    end

    xfer(0, 1, 32'hC, 32'h1234_5678, 4'hF, 0, "wr_c");
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 32'hC; pwdata[0] = 32'h5555_AAAA; pstrb[0] = 4'hF;
    @(posedge pclk); #1;
    penable[0] = 1'b1;
    @(posedge pclk); #1;
    presetn = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      chk("midreset_pready", 32'(pready[i]), 32'h0);
      chk("midreset_pslverr", 32'(pslverr[i]), 32'h0);
      chk("midreset_prdata", prdata[i], 32'h0);
    end
    psel[0] = 1'b0; penable[0] = 1'b0;
    model_reset();
    @(posedge pclk); #1;
    presetn = 1'b1;
    xfer(0, 0, 32'hC, 0, 4'h0, 0, "rd_c_after_reset");

    for (int b = 0; b < 30; b++) begin
      g = $urandom_range(0, 2);
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        w = 1'($urandom_range(0, 1));
        r = $urandom_range(0, 9);
        if (r < 7)      a = 32'($urandom_range(0, 17)) * 4;
        else if (r < 9) a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
        else            a = 32'h0000_1000 + 32'($urandom_range(0, 15)) * 4;
        xfer(g, w, a, $urandom(), 4'($urandom_range(0, 15)), k < n - 1, "rand");
      end
    end

    repeat (4) @(posedge pclk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
